// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, flag bit positions and the
// flag-writer class decode used by both decode and execute.
package wisc_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;

  // Bit positions inside the {Z,V,N} vector consumed by PC control.
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    FC_NONE = 2'd0,
    FC_Z    = 2'd1,
    FC_ZVN  = 2'd2
  } flag_class_e;

  function automatic flag_class_e flag_class(input logic [3:0] op);
    flag_class_e fc;
    case (op)
      OP_ADD, OP_SUB:                 fc = FC_ZVN;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: fc = FC_Z;
      default:                        fc = FC_NONE;
    endcase
    return fc;
  endfunction

  function automatic logic is_flag_writer(input logic [3:0] op);
    return flag_class(op) != FC_NONE;
  endfunction

endpackage

// File: rtl/flag_pend_shift.sv
// Pending flag-writer tracker: bit k marks a writer k+1 slots past ID,
// the top bit is the EX slot. Flush squashes everything younger than EX.
module flag_pend_shift #(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic             flush_i,
  input  logic             din_i,
  output logic [DEPTH-1:0] pend_o
);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Next state: flush wins over the shift; no advance means hold.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else if (adv_i) begin
      pend_d[0] = din_i;
      for (int k = 1; k < DEPTH; k++) begin
        pend_d[k] = pend_q[k-1];
      end
    end
  end

  // State register; reset clears pending writers asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/flag_unit.sv
// Flag register with same-cycle EX forwarding and a branch-hazard stall
// for flag writers still between ID and EX.
module flag_unit
  import wisc_pkg::*;
#(
  parameter int PEND_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_opcode,
  input  logic        id_is_branch,
  input  logic        pipe_adv,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [3:0]  ex_opcode,
  input  logic [15:0] ex_result,
  input  logic        ex_ovfl,
  output logic [2:0]  F,
  output logic [2:0]  F_q,
  output logic        br_stall,
  output logic [15:0] stall_cnt
);

  logic [2:0]            flags_q;
  logic [2:0]            flags_d;
  logic                  ex_wr;
  flag_class_e           ex_class;
  logic [PEND_DEPTH-1:0] pend;
  logic                  older_writer;
  logic                  id_writer;
  logic [15:0]           stall_cnt_q;
  logic [15:0]           stall_cnt_d;

  assign ex_wr     = ex_valid & pipe_adv;
  assign ex_class  = flag_class(ex_opcode);
  assign id_writer = id_valid & is_flag_writer(id_opcode) & ~br_stall;

  // Flags after a qualified EX write; unwritten flags keep their value.
  always_comb begin
    flags_d = flags_q;
    if (ex_wr && ex_class != FC_NONE) begin
      flags_d[FLAG_Z] = (ex_result == 16'h0000);
      if (ex_class == FC_ZVN) begin
        flags_d[FLAG_V] = ex_ovfl;
        flags_d[FLAG_N] = ex_result[15];
      end
    end
  end

  // Architectural flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 3'b000;
    else     flags_q <= flags_d;
  end

  // flags_d already equals flags_q when nothing writes, so it doubles as the
  // forwarded value.
  assign F   = flags_d;
  assign F_q = flags_q;

  flag_pend_shift #(
    .DEPTH (PEND_DEPTH)
  ) u_pend (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (pipe_adv),
    .flush_i (flush),
    .din_i   (id_writer),
    .pend_o  (pend)
  );

  // A writer already in EX is forwarded, so only the slots before EX stall.
  generate
    if (PEND_DEPTH == 1) begin : g_no_hazard
      assign older_writer = 1'b0;
    end else begin : g_hazard
      assign older_writer = |pend[PEND_DEPTH-2:0];
    end
  endgenerate

  assign br_stall = id_valid & id_is_branch & older_writer;

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (br_stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 16'h0000;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_opcode;
  logic        id_is_branch;
  logic        pipe_adv;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [15:0] ex_result;
  logic        ex_ovfl;
  logic [2:0]  F;
  logic [2:0]  F_q;
  logic        br_stall;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] XOR = 4'b0010;
  localparam logic [3:0] BR  = 4'b1100;
  localparam logic [3:0] NOP = 4'b1111;

  flag_unit #(.PEND_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_is_branch (id_is_branch),
    .pipe_adv     (pipe_adv),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_result    (ex_result),
    .ex_ovfl      (ex_ovfl),
    .F            (F),
    .F_q          (F_q),
    .br_stall     (br_stall),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // One clock edge; returns at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_opcode = NOP; id_is_branch = 0; pipe_adv = 1; flush = 0;
    ex_valid = 0; ex_opcode = NOP; ex_result = 16'h0000; ex_ovfl = 0;
  endtask

  task automatic set_ex(input logic v, input logic [3:0] op, input logic [15:0] r, input logic o);
    ex_valid = v; ex_opcode = op; ex_result = r; ex_ovfl = o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_checks++; if (F_q !== 3'b000) begin n_fail++; $display("FAIL reset_Fq got %b exp 000", F_q); end
    n_checks++; if (F !== 3'b000) begin n_fail++; $display("FAIL reset_F got %b exp 000", F); end
    n_checks++; if (br_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b exp 0", br_stall); end
    n_checks++; if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got %h exp 0000", stall_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_flags();
    set_ex(1, ADD, 16'h8000, 1'b1); #1;
    n_checks++; if (F !== 3'b011) begin n_fail++; $display("FAIL add_fwd got %b exp 011", F); end
    step();
    n_checks++; if (F_q !== 3'b011) begin n_fail++; $display("FAIL add_Fq got %b exp 011", F_q); end
    set_ex(1, XOR, 16'h0000, 1'b0); #1;
    n_checks++; if (F !== 3'b111) begin n_fail++; $display("FAIL xor_fwd got %b exp 111", F); end
    step();
    n_checks++; if (F_q !== 3'b111) begin n_fail++; $display("FAIL xor_Fq got %b exp 111", F_q); end
    set_ex(1, ADD, 16'h0001, 1'b0);
    step();
    n_checks++; if (F_q !== 3'b000) begin n_fail++; $display("FAIL add1_Fq got %b exp 000", F_q); end
    set_ex(1, NOP, 16'h0000, 1'b1); #1;
    n_checks++; if (F !== 3'b000) begin n_fail++; $display("FAIL nonwriter_fwd got %b exp 000", F); end
    step();
    n_checks++; if (F_q !== 3'b000) begin n_fail++; $display("FAIL nonwriter_Fq got %b exp 000", F_q); end
    set_ex(1, SUB, 16'h0000, 1'b1); pipe_adv = 0; #1;
    n_checks++; if (F !== 3'b000) begin n_fail++; $display("FAIL frozen_fwd got %b exp 000", F); end
    step();
    n_checks++; if (F_q !== 3'b000) begin n_fail++; $display("FAIL frozen_Fq got %b exp 000", F_q); end
    idle_inputs();
    step();
  endtask

  task automatic test_stall();
    id_valid = 1; id_opcode = SUB; id_is_branch = 0;
    #1;
    n_checks++; if (br_stall !== 1'b0) begin n_fail++; $display("FAIL writer_in_id_stall got %b exp 0", br_stall); end
    step();
    id_opcode = BR; id_is_branch = 1; #1;
    n_checks++; if (br_stall !== 1'b1) begin n_fail++; $display("FAIL stall_on got %b exp 1", br_stall); end
    step();
    set_ex(1, SUB, 16'hFFFF, 1'b0); #1;
    n_checks++; if (br_stall !== 1'b0) begin n_fail++; $display("FAIL stall_off got %b exp 0", br_stall); end
    n_checks++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL stall_cnt1 got %0d exp 1", stall_cnt); end
    n_checks++; if (F !== 3'b001) begin n_fail++; $display("FAIL branch_fwd got %b exp 001", F); end
    step();
    n_checks++; if (F_q !== 3'b001) begin n_fail++; $display("FAIL sub_Fq got %b exp 001", F_q); end
    idle_inputs();
    step();
  endtask

  task automatic test_adv_low();
    id_valid = 1; id_opcode = SUB;
    step();
    id_opcode = BR; id_is_branch = 1; pipe_adv = 0;
    set_ex(1, ADD, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (br_stall !== 1'b1) begin n_fail++; $display("FAIL adv_low_stall[%0d] got %b exp 1", i, br_stall); end
      n_checks++; if (F !== 3'b001) begin n_fail++; $display("FAIL adv_low_fwd[%0d] got %b exp 001", i, F); end
      step();
      n_checks++; if (F_q !== 3'b001) begin n_fail++; $display("FAIL adv_low_Fq[%0d] got %b exp 001", i, F_q); end
    end
    pipe_adv = 1; #1;
    n_checks++; if (br_stall !== 1'b1) begin n_fail++; $display("FAIL adv_resume_stall got %b exp 1", br_stall); end
    step();
    n_checks++; if (F_q !== 3'b110) begin n_fail++; $display("FAIL adv_resume_Fq got %b exp 110", F_q); end
    set_ex(0, NOP, 16'h0000, 1'b0); #1;
    n_checks++; if (br_stall !== 1'b0) begin n_fail++; $display("FAIL adv_done_stall got %b exp 0", br_stall); end
    n_checks++; if (stall_cnt !== 16'd5) begin n_fail++; $display("FAIL adv_cnt got %0d exp 5", stall_cnt); end
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    id_valid = 1; id_opcode = SUB;
    step();
    id_opcode = BR; id_is_branch = 1; flush = 1;
    set_ex(1, ADD, 16'h8000, 1'b0); #1;
    n_checks++; if (br_stall !== 1'b1) begin n_fail++; $display("FAIL flush_pre_stall got %b exp 1", br_stall); end
    step();
    flush = 0; set_ex(0, NOP, 16'h0000, 1'b0); #1;
    n_checks++; if (br_stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b exp 0", br_stall); end
    n_checks++; if (F_q !== 3'b001) begin n_fail++; $display("FAIL flush_Fq got %b exp 001", F_q); end
    n_checks++; if (stall_cnt !== 16'd6) begin n_fail++; $display("FAIL flush_cnt got %0d exp 6", stall_cnt); end
    step();
    n_checks++; if (br_stall !== 1'b0) begin n_fail++; $display("FAIL flush_after got %b exp 0", br_stall); end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_stall();
    id_valid = 1; id_opcode = SUB;
    step();
    id_opcode = BR; id_is_branch = 1; #1;
    n_checks++; if (br_stall !== 1'b1) begin n_fail++; $display("FAIL mid_pre_stall got %b exp 1", br_stall); end
    #1 rst = 1'b1; #1;
    n_checks++; if (br_stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stall got %b exp 0", br_stall); end
    n_checks++; if (F_q !== 3'b000) begin n_fail++; $display("FAIL mid_rst_Fq got %b exp 000", F_q); end
    n_checks++; if (F !== 3'b000) begin n_fail++; $display("FAIL mid_rst_F got %b exp 000", F); end
    n_checks++; if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_cnt got %h exp 0000", stall_cnt); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_saturate();
    id_valid = 1; id_opcode = SUB;
    step();
    id_opcode = BR; id_is_branch = 1; pipe_adv = 0;
    repeat (65534) step();
    n_checks++; if (stall_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre got %h exp fffe", stall_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (br_stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall[%0d] got %b exp 1", i, br_stall); end
      step();
      n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt[%0d] got %h exp ffff", i, stall_cnt); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_flags();
    test_stall();
    test_adv_low();
    test_flush();
    test_reset_mid_stall();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Flag register and branch-hazard tracker for the pipelined WISC core. The block captures the Z, V and N flags from the EX stage, then returns them to the branch logic in decode as the 3-bit `{Z,V,N}` vector the PC control consumes. It forwards same-cycle EX results to that branch logic. It also stalls a decode-stage branch while an older flag-writing instruction is still upstream of EX.

## Interface
Parameters:
- `PEND_DEPTH`, default 2: number of pipeline slots from ID exit to EX inclusive. Legal range 1–4.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  decode slot holds a valid instruction.
- `id_opcode`  in  4  decode-slot opcode.
- `id_is_branch`  in  1  decode instruction is B or BR.
- `pipe_adv`  in  1  back end (ID exit through EX) advances this cycle.
- `flush`  in  1  squash all pending flag writers younger than EX.
- `ex_valid`  in  1  EX slot holds a valid instruction.
- `ex_opcode`  in  4  EX-slot opcode.
- `ex_result`  in  16  ALU result.
- `ex_ovfl`  in  1  ALU signed overflow.
- `F`  out  3  forwarded flags `{Z,V,N}` for the branch in ID.
- `F_q`  out  3  architectural flag register `{Z,V,N}`.
- `br_stall`  out  1  hold the ID branch and insert a bubble downstream.
- `stall_cnt`  out  16  count of cycles with `br_stall` high, saturating.

## Operation
- Flag writer classes, by opcode:
  - ADD `0000` and SUB `0001` write Z, V and N.
  - XOR `0010`, SLL `0100`, SRA `0101` and ROR `0110` write Z only.
  - All other opcodes write no flags.
- Flag update happens at a clock edge with `ex_valid & pipe_adv`:
  - Z = (`ex_result` == 16'h0000).
  - V = `ex_ovfl`.
  - N = `ex_result[15]`.
  - Flags that the class does not write hold their value.
- `F` is combinational. It equals the value `F_q` will take at the next edge if an EX write is qualified, otherwise `F_q`.
- Pending tracker: a shift register `pend[PEND_DEPTH-1:0]`, where bit `k` marks a flag writer `k+1` slots past ID. The top bit is EX.
  - On a `pipe_adv` edge: `pend[0]` ← `id_valid & writer(id_opcode) & ~br_stall`, and `pend[k]` ← `pend[k-1]`.
  - With `pipe_adv` low, `pend` holds.
  - `flush` at an edge clears all `pend` bits and takes priority over the shift. The EX flag write still occurs.
- `br_stall` = `id_valid & id_is_branch & |pend[PEND_DEPTH-2:0]`.
  - EX-stage writers are covered by forwarding, so with `PEND_DEPTH`=1 `br_stall` is constant 0.
  - While stalled, ID holds and the back end keeps advancing with a bubble, so the writer drains and the stall resolves.
- `stall_cnt` increments on each edge with `br_stall` high and saturates at 16'hFFFF. It is cleared only by reset.

## Timing
- Reset values: `F_q`=3'b000, `pend`=0, `stall_cnt`=0. Consequently `F`=3'b000 with no EX write, and `br_stall`=0.
- A reset asserted mid-stall drops `br_stall` immediately, because `pend` clears asynchronously.
- Flag write latency is 1 edge: EX result to `F_q`. Latency to `F` is 0.
- Maximum stall is `PEND_DEPTH-1` cycles per branch when `pipe_adv` stays high. A low `pipe_adv` extends the stall cycle-for-cycle.
- A writer in ID together with a branch in ID cannot occur: there is one ID slot.
- `pipe_adv` low freezes the flags as well; an EX instruction writes exactly once.
- On a simultaneous `flush` and EX write, both take effect at the same edge.

## Structure
- Shared package `wisc_pkg` holds:
  - opcode constants `OP_ADD`, `OP_SUB`, `OP_XOR`, `OP_SLL`, `OP_SRA`, `OP_ROR`;
  - flag bit indices `FLAG_Z`=2, `FLAG_V`=1, `FLAG_N`=0, matching the PC control's `F` input.
- One natural sub-module, `flag_pend_shift`: the parameterised pending shift register with `flush`.
- The writer-class decode stays as a package function used by both stages.

## Test plan
- Reset, then ADD in EX with result 16'h8000, `ex_ovfl`=1, `pipe_adv`=1:
  - same cycle `F`=3'b011;
  - after the edge `F_q`=3'b011.
- After that, XOR in EX with result 0:
  - `F_q` becomes 3'b111, because Z is set and V and N hold.
  - An ADD result of 1 with no overflow afterwards gives 3'b000.
- `PEND_DEPTH`=2, SUB issued from ID, branch in ID next cycle:
  - `br_stall`=1 for exactly 1 cycle;
  - `stall_cnt`=1;
  - then the branch sees forwarded `F` from the SUB in EX.
- `pipe_adv` held low for 3 cycles during the stall:
  - `br_stall` stays 1 for 4 cycles total;
  - `F_q` unchanged until the first `pipe_adv` edge with EX valid.
- `flush` with `pend`=2'b01 and a branch in ID:
  - after the edge `pend`=0 and `br_stall`=0;
  - a concurrent EX ADD still updates `F_q`.
- Force `stall_cnt` to 16'hFFFE, hold `br_stall` high for 3 cycles: the counter reads 16'hFFFF and stays there. Separately, assert `rst` mid-stall: all outputs return to 0 without waiting for a clock edge.
